// File: rtl/idiv_iter.sv
// Iterative radix-2 restoring divider: signed/unsigned quotient or remainder,
// 64-bit or 32-bit mode, start/busy/done handshake with one op in flight.
module idiv_iter #(
  parameter int unsigned W     = 64,
  parameter int unsigned FLG_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clkEn,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic             kill,
  input  logic [W:0]       R,
  input  logic [W:0]       C,
  output logic             busy,
  output logic             done,
  output logic [W:0]       Res,
  output logic [FLG_W-1:0] flg
);

  localparam int unsigned HW    = W / 2;
  localparam int unsigned CNT_W = $clog2(W) + 1;
  localparam logic [W-1:0]  MIN_W = {1'b1, {(W-1){1'b0}}};
  localparam logic [HW-1:0] MIN_H = {1'b1, {(HW-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_FIX, S_DONE} state_t;

  state_t           state;
  logic [2:0]       op_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sign_q_q, sign_r_q, dz_q, ov_q;

  logic             is_signed_c, is_short_c, sel_rem_c;
  logic [W-1:0]     a_ext_c, b_ext_c, a_abs_c, b_abs_c, a_mode_c;
  logic             a_neg_c, b_neg_c, dz_c, ov_c;
  logic [W:0]       shift_c, diff_c;
  logic             ge_c;
  logic [W-1:0]     q_fix_c, r_fix_c, res_c, res_m_c;
  logic [5:0]       flg_c;
  logic             unused_bits_c;

  assign unused_bits_c = ^{R[W], C[W], diff_c[W]};

  // Operand conditioning, restoring step and result fix-up datapath
  always_comb begin
    is_signed_c = op_q[0];
    is_short_c  = op_q[1];
    sel_rem_c   = op_q[2];

    a_ext_c = a_q;
    b_ext_c = b_q;
    if (is_short_c) begin
      a_ext_c = is_signed_c ? {{HW{a_q[HW-1]}}, a_q[HW-1:0]} : {{HW{1'b0}}, a_q[HW-1:0]};
      b_ext_c = is_signed_c ? {{HW{b_q[HW-1]}}, b_q[HW-1:0]} : {{HW{1'b0}}, b_q[HW-1:0]};
    end
    a_neg_c  = is_signed_c & a_ext_c[W-1];
    b_neg_c  = is_signed_c & b_ext_c[W-1];
    a_abs_c  = a_neg_c ? (~a_ext_c + W'(1)) : a_ext_c;
    b_abs_c  = b_neg_c ? (~b_ext_c + W'(1)) : b_ext_c;
    a_mode_c = is_short_c ? {{HW{1'b0}}, a_q[HW-1:0]} : a_q;

    dz_c = (b_ext_c == '0);
    if (is_short_c)
      ov_c = is_signed_c && (a_q[HW-1:0] == MIN_H) && (b_q[HW-1:0] == '1);
    else
      ov_c = is_signed_c && (a_q == MIN_W) && (b_q == '1);

    shift_c = {rem_q, quo_q[W-1]};
    diff_c  = shift_c - {1'b0, dvs_q};
    ge_c    = (shift_c >= {1'b0, dvs_q});

    q_fix_c = sign_q_q ? (~quo_q + W'(1)) : quo_q;
    r_fix_c = sign_r_q ? (~rem_q + W'(1)) : rem_q;
    res_c   = sel_rem_c ? r_fix_c : q_fix_c;
    if (dz_q)
      res_c = sel_rem_c ? a_mode_c : '1;
    else if (ov_q)
      res_c = sel_rem_c ? '0 : a_mode_c;
    res_m_c = is_short_c ? {{HW{1'b0}}, res_c[HW-1:0]} : res_c;

    flg_c = {dz_q, ov_q, 1'b0,
             (is_short_c ? res_m_c[HW-1] : res_m_c[W-1]),
             (res_m_c == '0),
             ~^res_m_c[7:0]};
  end

  // Control FSM with registered handshake, result and flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_q_q <= 1'b0;
      sign_r_q <= 1'b0;
      dz_q     <= 1'b0;
      ov_q     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Res      <= '0;
      flg      <= '0;
    end else if (clkEn) begin
      if (kill) begin
        // In IDLE these are already clear, so kill is a no-op there
        state <= S_IDLE;
        busy  <= 1'b0;
        done  <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
            if (en) begin
              op_q  <= op;
              a_q   <= R[W-1:0];
              b_q   <= C[W-1:0];
              busy  <= 1'b1;
              state <= S_PREP;
            end
          end
          S_PREP: begin
            // Short mode parks the dividend in the upper half so N=32 steps suffice
            quo_q    <= is_short_c ? {a_abs_c[HW-1:0], {HW{1'b0}}} : a_abs_c;
            rem_q    <= '0;
            dvs_q    <= b_abs_c;
            cnt_q    <= is_short_c ? CNT_W'(HW) : CNT_W'(W);
            sign_q_q <= a_neg_c ^ b_neg_c;
            sign_r_q <= a_neg_c;
            dz_q     <= dz_c;
            ov_q     <= ov_c & ~dz_c;
            state    <= (dz_c || ov_c) ? S_FIX : S_ITER;
          end
          S_ITER: begin
            rem_q <= ge_c ? diff_c[W-1:0] : shift_c[W-1:0];
            quo_q <= {quo_q[W-2:0], ge_c};
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1))
              state <= S_FIX;
          end
          S_FIX: begin
            Res   <= {1'b0, res_m_c};
            flg   <= FLG_W'(flg_c);
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= S_DONE;
          end
          S_DONE: begin
            done  <= 1'b0;
            state <= S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_idiv_iter.sv
// Scoreboard bench for idiv_iter: driver pushes expected results at accept,
// a negedge monitor pops and compares on each done pulse.
module tb_idiv_iter;

  logic        clk, rst, clkEn, en, kill;
  logic [2:0]  op;
  logic [64:0] R, C, Res;
  logic        busy, done;
  logic [5:0]  flg;

  idiv_iter #(.W(64), .FLG_W(6)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .en(en), .op(op), .kill(kill),
    .R(R), .C(C), .busy(busy), .done(done), .Res(Res), .flg(flg)
  );

  typedef struct {
    logic [64:0] res;
    logic [5:0]  flg;
    int          lat;
    int          acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   cycle   = 0;
  logic done_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Monitor: compare on each rising done against the oldest expectation
  always @(negedge clk) begin
    if (rst && done && !done_prev) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: got Res=0x%h expected no done", Res);
      end else begin
        mon_e = sb.pop_front();
        check("res", Res, mon_e.res);
        check("flg", 65'(flg), 65'(mon_e.flg));
        check("latency", 65'(cycle - mon_e.acc + 1), 65'(mon_e.lat));
      end
    end
    done_prev = done;
  end

  task automatic start(input logic [2:0] o, input logic [64:0] r, input logic [64:0] c,
                       input bit push, input logic [64:0] eres, input logic [5:0] eflg,
                       input int lat);
    exp_t e;
    @(negedge clk);
    en = 1'b1; op = o; R = r; C = c;
    @(posedge clk);
    #1;
    en = 1'b0;
    check("busy_on_accept", 65'(busy), 65'(1));
    if (push) begin
      e.res = eres; e.flg = eflg; e.lat = lat; e.acc = cycle;
      sb.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(posedge clk);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL timeout: got %0d pending results expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    check({name, "_busy"}, 65'(busy), 65'(0));
    check({name, "_done"}, 65'(done), 65'(0));
    check({name, "_res"},  Res, 65'(0));
    check({name, "_flg"},  65'(flg), 65'(0));
  endtask

  initial begin
    rst = 1'b0; clkEn = 1'b1; en = 1'b0; kill = 1'b0; op = 3'b000; R = '0; C = '0;
    #1;
    check_zero("reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;

    // 64-bit unsigned quotient 100/7
    start(3'b000, 65'd100, 65'd7, 1'b1, 65'd14, 6'b000000, 67);
    wait_idle();
    // 64-bit signed remainder -7 % 2 = -1
    start(3'b101, 65'h0_FFFF_FFFF_FFFF_FFF9, 65'd2, 1'b1,
          65'h0_FFFF_FFFF_FFFF_FFFF, 6'b000101, 67);
    wait_idle();
    // 32-bit signed divide by zero
    start(3'b011, 65'd5, 65'd0, 1'b1, 65'h0_0000_0000_FFFF_FFFF, 6'b100101, 3);
    wait_idle();
    // 32-bit signed overflow: min / -1
    start(3'b011, 65'h0_0000_0000_8000_0000, 65'h0_0000_0000_FFFF_FFFF, 1'b1,
          65'h0_0000_0000_8000_0000, 6'b010101, 3);
    wait_idle();
    // 32-bit signed quotient -100/7 = -14
    start(3'b011, 65'h0_0000_0000_FFFF_FF9C, 65'd7, 1'b1,
          65'h0_0000_0000_FFFF_FFF2, 6'b000100, 35);
    wait_idle();
    // 64-bit unsigned max / 16
    start(3'b000, 65'h0_FFFF_FFFF_FFFF_FFFF, 65'd16, 1'b1,
          65'h0_0FFF_FFFF_FFFF_FFFF, 6'b000001, 67);
    wait_idle();

    // clkEn held low 10 cycles mid-ITER, with en pulses while busy
    start(3'b000, 65'd1000, 65'd10, 1'b1, 65'd100, 6'b000000, 77);
    repeat (5) @(negedge clk);
    en = 1'b1; R = 65'd7; C = 65'd7;
    @(negedge clk);
    en = 1'b0;
    repeat (4) @(negedge clk);
    clkEn = 1'b0;
    repeat (10) @(negedge clk);
    clkEn = 1'b1;
    wait_idle();

    // kill mid-ITER: no done, result unchanged, then a fresh 9/3
    start(3'b000, 65'd1000, 65'd10, 1'b0, '0, '0, 0);
    repeat (21) @(negedge clk);
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    check("kill_busy", 65'(busy), 65'(0));
    check("kill_done", 65'(done), 65'(0));
    repeat (80) @(negedge clk);
    check("kill_res_hold", Res, 65'd100);
    check("kill_flg_hold", 65'(flg), 65'(0));
    start(3'b000, 65'd9, 65'd3, 1'b1, 65'd3, 6'b000001, 67);
    wait_idle();

    // Async reset mid-ITER
    start(3'b000, 65'd1000, 65'd10, 1'b0, '0, '0, 0);
    repeat (30) @(negedge clk);
    rst = 1'b0;
    #1;
    check_zero("midreset");
    @(negedge clk);
    rst = 1'b1;
    repeat (80) @(negedge clk);

    // 32-bit unsigned remainder; upper operand bits must be ignored
    start(3'b110, 65'h0_FFFF_FFFF_0000_0064, 65'h0_0000_0001_0000_0007, 1'b1,
          65'd2, 6'b000000, 35);
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
